// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access unit (LB/LH/LW/LBU/LHU/SB/SH/SW) between datapath and RAM.
// Ports: clockCPU, reset (async, active-high); req/we/funct3/addr/wdata request, captured in IDLE;
//   busy/done/err/rdata status and load result; mem_addr/mem_wdata/mem_wren/mem_be out, mem_q in (RAM).
// Macro LSU_BYTE_ENABLE_EN: drive real byte enables and write SB/SH in one cycle; otherwise mem_be is
//   tied to all ones and SB/SH are read-modify-write.
module load_store_unit #(
  parameter int ADDR_W = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic              clockCPU,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wren,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_q
);
  typedef enum logic [2:0] {IDLE, RD_WAIT, LOAD_DONE, WRITE, DONE} state_t;
  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(RD_LATENCY);
`ifdef LSU_BYTE_ENABLE_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
  assign mem_be = 4'b1111;
`endif
  state_t state;
  logic [CW-1:0] cnt;
  logic st_r;
  logic [2:0] f3_r;
  logic [1:0] lane;
  logic [15:0] wd_r;
  logic ok, direct;
  logic [7:0] q_b;
  logic [15:0] q_h;
  logic [31:0] wd_rep, ld_val, merged;
  logic unused_addr;
  // bank select above the word address is decoded outside
  assign unused_addr = ^addr[31:ADDR_W+2];
  always_comb begin
    ok = !(funct3 inside {3'b011, 3'b110, 3'b111}) && !(we && funct3[2]) &&
         (funct3[1] ? addr[1:0] == 2'b00 : !(funct3[0] && addr[0]));
    direct = we && (funct3[1] || BE);
    wd_rep = funct3[1] ? wdata : funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    q_b = mem_q[{lane, 3'b000} +: 8];
    q_h = mem_q[{lane[1], 4'b0000} +: 16];
    ld_val = f3_r[1] ? mem_q : f3_r[0] ? {{16{q_h[15] & ~f3_r[2]}}, q_h} : {{24{q_b[7] & ~f3_r[2]}}, q_b};
    merged = mem_q;
    if (f3_r[0]) merged[{lane[1], 4'b0000} +: 16] = wd_r;
    else merged[{lane, 3'b000} +: 8] = wd_r[7:0];
  end
  // cnt runs 0..RD_LATENCY inside RD_WAIT; mem_q is valid in the cycle where cnt reaches RD_LATENCY
  always_ff @(posedge clockCPU or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      st_r <= 1'b0;
      f3_r <= '0;
      lane <= '0;
      wd_r <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wren <= 1'b0;
`ifdef LSU_BYTE_ENABLE_EN
      mem_be <= 4'b0000;
`endif
    end else begin
      mem_wren <= 1'b0;
      case (state)
        IDLE: if (req) begin
          busy <= 1'b1;
          st_r <= we;
          f3_r <= funct3;
          lane <= addr[1:0];
          wd_r <= wdata[15:0];
          cnt <= '0;
          mem_addr <= addr[ADDR_W+1:2];
          if (!ok) begin
            done <= 1'b1;
            err <= 1'b1;
            state <= DONE;
          end else if (direct) begin
            mem_wren <= 1'b1;
            mem_wdata <= wd_rep;
`ifdef LSU_BYTE_ENABLE_EN
            mem_be <= funct3[1] ? 4'b1111 : funct3[0] ? 4'b0011 << {addr[1], 1'b0} : 4'b0001 << addr[1:0];
`endif
            state <= WRITE;
          end else state <= RD_WAIT;
        end
        RD_WAIT:
          if (cnt != LAT) cnt <= cnt + 1'b1;
          else if (st_r) begin
            mem_wren <= 1'b1;
            mem_wdata <= merged;
            state <= WRITE;
          end else begin
            rdata <= ld_val;
            done <= 1'b1;
            state <= LOAD_DONE;
          end
        WRITE: begin
          done <= 1'b1;
`ifdef LSU_BYTE_ENABLE_EN
          mem_be <= 4'b0000;
`endif
          state <= DONE;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
          err <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized self-checking bench for load_store_unit against a byte-level model.
module tb_load_store_unit;
  localparam int LAT = 1;
`ifdef LSU_BYTE_ENABLE_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif
  localparam logic [3:0] RST_BE = BE ? 4'h0 : 4'hF;
  localparam logic [2:0] LD_F [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  localparam logic [31:0] LD_A [5] = '{32'h5, 32'h5, 32'h6, 32'h4, 32'h4};
  localparam logic [31:0] LD_X [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
  localparam logic IL_W [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [2:0] IL_F [8] = '{3'd2, 3'd1, 3'd4, 3'd3, 3'd6, 3'd2, 3'd1, 3'd7};
  localparam logic [31:0] IL_A [8] = '{32'h2, 32'h1, 32'h0, 32'h0, 32'h4, 32'h1, 32'h3, 32'h8};

  typedef struct {
    logic err;
    logic [31:0] rdata;
    int done_k;
    int wr_k;
    logic [31:0] word;
    logic [3:0] be;
  } exp_t;

  logic clockCPU = 1'b0, reset = 1'b1, req = 1'b0, we = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic busy, done, err, mem_wren;
  logic [31:0] rdata, mem_wdata, mem_q;
  logic [9:0] mem_addr;
  logic [3:0] mem_be;
  logic [31:0] ram [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic load_ram = 1'b0;
  logic [31:0] last_rdata = '0;
  int checks = 0, errors = 0;
  int o_done_k, o_ndone, o_wr_k, o_nwr;
  logic o_err, o_rule;
  logic [3:0] o_be;
  logic [31:0] o_rdata;

  load_store_unit #(.ADDR_W(10), .RD_LATENCY(LAT)) dut (
    .clockCPU(clockCPU), .reset(reset), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_be(mem_be), .mem_q(mem_q)
  );

  always #5 clockCPU = ~clockCPU;

  // synchronous RAM, one cycle read latency, byte-masked writes
  always @(posedge clockCPU) begin
    mem_q <= ram[mem_addr];
    if (load_ram) for (int i = 0; i < 1024; i++) ram[i] <= ref_mem[i];
    else if (mem_wren) for (int i = 0; i < 4; i++) if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  // expected outcome of one access from the RV32I rules, on the byte view of the shadow memory
  function automatic exp_t model(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int sz;
    logic [31:0] m, v;
    sz = f[1:0] == 2'd0 ? 1 : f[1:0] == 2'd1 ? 2 : 4;
    e.word = ref_mem[a[11:2]];
    e.rdata = last_rdata;
    e.wr_k = 0;
    e.be = 4'(((1 << sz) - 1) << a[1:0]);
    if (!BE) e.be = 4'hF;
    e.err = f[1:0] == 2'd3 || (w ? f[2] : f[2] && f[1]) || (int'(a[1:0]) % sz) != 0;
    if (e.err) e.done_k = 1;
    else if (!w) begin
      m = sz == 4 ? 32'hFFFFFFFF : (32'd1 << (8 * sz)) - 32'd1;
      v = (e.word >> (8 * a[1:0])) & m;
      if (!f[2] && v[8*sz-1]) v = v | ~m;
      e.rdata = v;
      e.done_k = 2 + LAT;
    end else begin
      for (int i = 0; i < sz; i++) e.word[8*(int'(a[1:0]) + i) +: 8] = d[8*i +: 8];
      e.wr_k = (sz == 4 || BE) ? 1 : 2 + LAT;
      e.done_k = e.wr_k + 1;
    end
    return e;
  endfunction

  // issue one request and record what the DUT does over the following 12 cycles
  task automatic run_op(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d, input bit hold);
    logic prev_wr;
    @(negedge clockCPU);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    o_done_k = 0; o_ndone = 0; o_wr_k = 0; o_nwr = 0;
    o_err = 1'bx; o_rdata = 'x; o_be = 'x; o_rule = 1'b0; prev_wr = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clockCPU);
      if (!hold || (o_done_k != 0 && k > o_done_k)) req = 1'b0;
      we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      if (done === 1'b1) begin
        if (o_done_k == 0) begin
          o_done_k = k; o_err = err; o_rdata = rdata;
        end
        o_ndone++;
      end
      if (err === 1'b1 && done !== 1'b1) o_rule = 1'b1;
      if (mem_wren === 1'b1) begin
        if (o_wr_k == 0) begin
          o_wr_k = k; o_be = mem_be;
        end
        o_nwr++;
        if (prev_wr || done === 1'b1) o_rule = 1'b1;
      end
      if (busy !== (o_done_k == 0 || k == o_done_k)) o_rule = 1'b1;
      prev_wr = mem_wren === 1'b1;
    end
    req = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clockCPU);
    checks++;
    if ({busy, done, err, mem_wren, rdata, mem_addr, mem_wdata, mem_be} !== {4'b0, 32'h0, 10'h0, 32'h0, RST_BE}) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b err=%b wren=%b rdata=%h maddr=%h mwdata=%h be=%b, expected zeros be=%b",
               busy, done, err, mem_wren, rdata, mem_addr, mem_wdata, mem_be, RST_BE);
    end
    reset = 1'b0;
    @(negedge clockCPU);
    checks++;
    if ({busy, done, mem_wren} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b wren=%b, expected 000", busy, done, mem_wren);
    end
  endtask

  task automatic test_loads;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, LD_F[i], LD_A[i], $urandom, 1'b0);
      checks++;
      if (o_rdata !== LD_X[i]) begin
        errors++;
        $display("FAIL load_%0d_rdata: got %h expected %h", i, o_rdata, LD_X[i]);
      end
      checks++;
      if (o_done_k !== 2 + LAT || o_ndone !== 1 || o_nwr !== 0 || o_err !== 1'b0 || o_rule !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d_ctrl: got done_k=%0d ndone=%0d nwr=%0d err=%b rule=%b expected %0d 1 0 0 0",
                 i, o_done_k, o_ndone, o_nwr, o_err, o_rule, 2 + LAT);
      end
      last_rdata = LD_X[i];
    end
  endtask

  task automatic test_illegal;
    for (int i = 0; i < 8; i++) begin
      run_op(IL_W[i], IL_F[i], IL_A[i], $urandom, 1'b0);
      checks++;
      if (o_done_k !== 1 || o_err !== 1'b1 || o_ndone !== 1 || o_nwr !== 0 || o_rule !== 1'b0) begin
        errors++;
        $display("FAIL illegal_%0d_ctrl: got done_k=%0d err=%b ndone=%0d nwr=%0d rule=%b expected 1 1 1 0 0",
                 i, o_done_k, o_err, o_ndone, o_nwr, o_rule);
      end
      checks++;
      if (o_rdata !== last_rdata || ram[IL_A[i][11:2]] !== ref_mem[IL_A[i][11:2]]) begin
        errors++;
        $display("FAIL illegal_%0d_state: got rdata=%h mem=%h expected %h %h",
                 i, o_rdata, ram[IL_A[i][11:2]], last_rdata, ref_mem[IL_A[i][11:2]]);
      end
    end
  endtask

  task automatic test_reset_abort;
    int nwr = 0;
    @(negedge clockCPU);
    req = 1'b1; we = 1'b1; funct3 = 3'd0; addr = 32'h7; wdata = 32'h123;
    @(negedge clockCPU);
    req = 1'b0; addr = $urandom;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy: got %b expected 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, mem_wren, rdata, mem_addr, mem_wdata, mem_be} !== {4'b0, 32'h0, 10'h0, 32'h0, RST_BE}) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%b done=%b err=%b wren=%b rdata=%h maddr=%h mwdata=%h be=%b, expected zeros",
               busy, done, err, mem_wren, rdata, mem_addr, mem_wdata, mem_be);
    end
    for (int k = 0; k < 9; k++) begin
      @(negedge clockCPU);
      if (k == 2) reset = 1'b0;
      if (mem_wren === 1'b1 || done === 1'b1) nwr++;
    end
    checks++;
    if (nwr !== 0 || ram[1] !== 32'h8899AABB) begin
      errors++;
      $display("FAIL abort_no_write: got activity=%0d mem1=%h expected 0 8899aabb", nwr, ram[1]);
    end
    last_rdata = '0;
    run_op(1'b0, 3'd2, 32'h4, $urandom, 1'b0);
    checks++;
    if (o_rdata !== 32'h8899AABB || o_done_k !== 2 + LAT || o_rule !== 1'b0) begin
      errors++;
      $display("FAIL abort_then_lw: got rdata=%h done_k=%0d rule=%b expected 8899aabb %0d 0", o_rdata, o_done_k, o_rule, 2 + LAT);
    end
    last_rdata = 32'h8899AABB;
  endtask

  task automatic test_sub_word_store;
    int wr_k;
    wr_k = BE ? 1 : 2 + LAT;
    run_op(1'b1, 3'd0, 32'h7, 32'h123, 1'b0);
    checks++;
    if (o_wr_k !== wr_k || o_nwr !== 1 || o_done_k !== wr_k + 1 || o_ndone !== 1 || o_rule !== 1'b0) begin
      errors++;
      $display("FAIL sb_timing: got wr_k=%0d nwr=%0d done_k=%0d ndone=%0d rule=%b expected %0d 1 %0d 1 0",
               o_wr_k, o_nwr, o_done_k, o_ndone, o_rule, wr_k, wr_k + 1);
    end
    checks++;
    if (ram[1] !== 32'h2399AABB || o_be !== (BE ? 4'b1000 : 4'b1111) || o_rdata !== last_rdata) begin
      errors++;
      $display("FAIL sb_data: got mem=%h be=%b rdata=%h expected 2399aabb %b %h", ram[1], o_be, o_rdata,
               BE ? 4'b1000 : 4'b1111, last_rdata);
    end
    ref_mem[1] = 32'h2399AABB;
  endtask

  task automatic test_req_held;
    logic [31:0] d;
    run_op(1'b0, 3'd2, 32'hC, $urandom, 1'b1);
    checks++;
    if (o_ndone !== 1 || o_nwr !== 0 || o_done_k !== 2 + LAT || o_rdata !== ref_mem[3] || o_rule !== 1'b0) begin
      errors++;
      $display("FAIL held_load: got ndone=%0d nwr=%0d done_k=%0d rdata=%h rule=%b expected 1 0 %0d %h 0",
               o_ndone, o_nwr, o_done_k, o_rdata, o_rule, 2 + LAT, ref_mem[3]);
    end
    last_rdata = ref_mem[3];
    d = $urandom;
    run_op(1'b1, 3'd2, 32'h8, d, 1'b1);
    checks++;
    if (o_ndone !== 1 || o_nwr !== 1 || o_done_k !== 2 || ram[2] !== d || o_rule !== 1'b0) begin
      errors++;
      $display("FAIL held_store: got ndone=%0d nwr=%0d done_k=%0d mem=%h rule=%b expected 1 1 2 %h 0",
               o_ndone, o_nwr, o_done_k, ram[2], o_rule, d);
    end
    ref_mem[2] = d;
  endtask

  task automatic test_back_to_back;
    int k1 = 0, k2 = 0, nd = 0;
    logic [31:0] r1 = 'x, d;
    d = $urandom;
    @(negedge clockCPU);
    req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h10;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clockCPU);
      if (k == 1) req = 1'b0;
      if (done === 1'b1) begin
        nd++;
        if (k1 == 0) begin
          k1 = k; r1 = rdata;
          req = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 32'h14; wdata = d;
        end else if (k2 == 0) k2 = k;
      end
      if (k1 != 0 && k == k1 + 2) req = 1'b0;
    end
    req = 1'b0;
    checks++;
    if (k1 !== 2 + LAT || k2 !== k1 + 3 || nd !== 2) begin
      errors++;
      $display("FAIL b2b_order: got k1=%0d k2=%0d ndone=%0d expected %0d %0d 2", k1, k2, nd, 2 + LAT, 5 + LAT);
    end
    checks++;
    if (r1 !== ref_mem[4] || ram[5] !== d) begin
      errors++;
      $display("FAIL b2b_data: got rdata=%h mem=%h expected %h %h", r1, ram[5], ref_mem[4], d);
    end
    ref_mem[5] = d;
    last_rdata = r1;
  endtask

  task automatic test_random;
    exp_t e;
    logic w;
    logic [2:0] f;
    logic [31:0] a, d;
    for (int n = 0; n < 80; n++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      a[11:2] = 10'($urandom_range(0, 15));
      d = $urandom;
      e = model(w, f, a, d);
      run_op(w, f, a, d, 1'b0);
      checks++;
      if (o_done_k !== e.done_k || o_err !== e.err || o_ndone !== 1 || o_rule !== 1'b0) begin
        errors++;
        $display("FAIL rand_%0d_ctrl we=%b f3=%0d a=%h: got done_k=%0d err=%b ndone=%0d rule=%b expected %0d %b 1 0",
                 n, w, f, a, o_done_k, o_err, o_ndone, o_rule, e.done_k, e.err);
      end
      checks++;
      if (o_wr_k !== e.wr_k || o_nwr !== (e.wr_k != 0 ? 1 : 0) || (e.wr_k != 0 && o_be !== e.be)) begin
        errors++;
        $display("FAIL rand_%0d_write we=%b f3=%0d a=%h: got wr_k=%0d nwr=%0d be=%b expected %0d be=%b",
                 n, w, f, a, o_wr_k, o_nwr, o_be, e.wr_k, e.be);
      end
      checks++;
      if (o_rdata !== e.rdata) begin
        errors++;
        $display("FAIL rand_%0d_rdata we=%b f3=%0d a=%h: got %h expected %h", n, w, f, a, o_rdata, e.rdata);
      end
      checks++;
      if (ram[a[11:2]] !== e.word) begin
        errors++;
        $display("FAIL rand_%0d_mem we=%b f3=%0d a=%h: got %h expected %h", n, w, f, a, ram[a[11:2]], e.word);
      end
      ref_mem[a[11:2]] = e.word;
      last_rdata = e.rdata;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
    ref_mem[1] = 32'h8899AABB;
    load_ram = 1'b1;
    @(negedge clockCPU);
    load_ram = 1'b0;
    test_reset;
    test_loads;
    test_illegal;
    test_reset_abort;
    test_sub_word_store;
    test_req_held;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
